// File: rtl/seq_reg_engine.sv
`default_nettype none
// ============================================================================
//  Module      : seq_reg_engine
//  Description : Small sequencing engine. A run walks IDLE -> INIT -> LOOP
//                (LOOP_N times) -> CALC -> FIN -> IDLE and leaves its results
//                in four 8-bit registers:
//                  a = 1, b = LOOP_N mod 256, c = b + 2 mod 256, d = a - 1.
//                'done' pulses for the single cycle after the FIN edge.
//                'hold' freezes the engine completely while it is busy.
//  Parameters  : LOOP_N  number of LOOP iterations (0..255), default 5
//  Ports       : clk    in   clock, rising edge
//                rst    in   asynchronous active-high reset
//                start  in   run request, sampled only in IDLE
//                hold   in   freeze request, honoured only while busy
//                a..d   out  8-bit result registers (b doubles as loop count)
//                busy   out  high in INIT, LOOP, CALC, FIN
//                done   out  one-cycle completion pulse
//  Options     : SEQ_AUTOSTART_EN  when defined, one run starts by itself at
//                the first edge after reset releases (once per reset).
//  Revision    : 1.0  initial release
// ============================================================================
module seq_reg_engine #(
  parameter int LOOP_N = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] c,
  output logic [7:0] d,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_LOOP = 3'd2,
    S_CALC = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [7:0] LOOP_CNT = 8'(LOOP_N);

  state_t state;
  logic   go;

`ifdef SEQ_AUTOSTART_EN
  // Set at the first edge after reset; until then IDLE behaves as if start=1.
  logic auto_fired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_fired <= 1'b0;
    end else begin
      auto_fired <= 1'b1;
    end
  end

  assign go = start | ~auto_fired;
`else
  assign go = start;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      a     <= 8'd0;
      b     <= 8'd0;
      c     <= 8'd0;
      d     <= 8'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (!(hold && busy)) begin
      // A held edge skips everything, including clearing 'done'.
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            state <= S_INIT;
            busy  <= 1'b1;
          end
        end
        S_INIT: begin
          a <= 8'd1;
          b <= 8'd0;
          c <= 8'd0;
          d <= 8'd0;
          if (LOOP_N > 0) begin
            state <= S_LOOP;
          end else begin
            state <= S_CALC;
          end
        end
        S_LOOP: begin
          // b starts at 0, so it equals the iteration count after increment.
          b <= b + 8'd1;
          if ((b + 8'd1) == LOOP_CNT) begin
            state <= S_CALC;
          end
        end
        S_CALC: begin
          c     <= b + 8'd2;
          state <= S_FIN;
        end
        S_FIN: begin
          d     <= a - 8'd1;
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_reg_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_reg_engine
//  Description : Self-checking bench for seq_reg_engine. Three instances with
//                LOOP_N = 5, 0 and 255 share clock and reset. A per-cycle
//                vector table exercises the LOOP_N=5 instance; hand-written
//                sequences cover latency, hold, mid-run reset and wrap cases.
//                With SEQ_AUTOSTART_EN defined only the autostart run is used.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_reg_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start5 = 1'b0, hold5 = 1'b0;
  logic start0 = 1'b0, start255 = 1'b0, hold_x = 1'b0;

  logic [7:0] a5, b5, c5, d5, a0, b0, c0, d0, a255, b255, c255, d255;
  logic busy5, done5, busy0, done0, busy255, done255;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_reg_engine #(.LOOP_N(5)) u_n5 (
    .clk(clk), .rst(rst), .start(start5), .hold(hold5),
    .a(a5), .b(b5), .c(c5), .d(d5), .busy(busy5), .done(done5));

  seq_reg_engine #(.LOOP_N(0)) u_n0 (
    .clk(clk), .rst(rst), .start(start0), .hold(hold_x),
    .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0));

  seq_reg_engine #(.LOOP_N(255)) u_n255 (
    .clk(clk), .rst(rst), .start(start255), .hold(hold_x),
    .a(a255), .b(b255), .c(c255), .d(d255), .busy(busy255), .done(done255));

  typedef struct {
    logic       start;
    logic       hold;
    logic [7:0] a, b, c, d;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string name, input logic [7:0] aa, bb, cc, dd,
                          input logic [7:0] ea, eb, ec, ed);
    chk({name, ".abcd"}, {aa, bb, cc, dd}, {ea, eb, ec, ed});
  endtask

  // Pulse start on the selected instance, then count edges after the start
  // edge until done is seen (bounded). Returns the edge count and checks that
  // done is a single-cycle pulse.
  task automatic run_count(input int sel, input int limit, output int edges);
    logic dn;
    edges = 0;
    case (sel)
      0:       start0   = 1'b1;
      255:     start255 = 1'b1;
      default: start5   = 1'b1;
    endcase
    @(negedge clk);
    start0 = 1'b0; start255 = 1'b0; start5 = 1'b0;
    dn = 1'b0;
    while (!dn && edges < limit) begin
      @(negedge clk);
      edges++;
      dn = (sel == 0) ? done0 : (sel == 255) ? done255 : done5;
    end
    if (!dn) begin
      n_chk++;
      n_fail++;
      $display("FAIL run_timeout sel=%0d: no done within %0d edges", sel, limit);
    end
    @(negedge clk);
    dn = (sel == 0) ? done0 : (sel == 255) ? done255 : done5;
    chk("done_one_cycle", {31'd0, dn}, 32'd0);
  endtask

  initial begin
    int edges;
    int pulses;

    // idle-with-hold, start+hold accepted, full run, restart with holds
    vecs[0]  = '{1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'd1, 8'd1, 8'd0, 8'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'd1, 8'd2, 8'd0, 8'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'd1, 8'd3, 8'd0, 8'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'd1, 8'd4, 8'd0, 8'd0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'd1, 8'd5, 8'd0, 8'd0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'd1, 8'd5, 8'd7, 8'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'd1, 8'd5, 8'd7, 8'd0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 8'd1, 8'd5, 8'd7, 8'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'd1, 8'd5, 8'd7, 8'd0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'd1, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 8'd1, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 8'd1, 8'd1, 8'd0, 8'd0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 8'd1, 8'd2, 8'd0, 8'd0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 8'd1, 8'd3, 8'd0, 8'd0, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 8'd1, 8'd4, 8'd0, 8'd0, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 8'd1, 8'd5, 8'd0, 8'd0, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 8'd1, 8'd5, 8'd0, 8'd0, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 8'd1, 8'd5, 8'd7, 8'd0, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 8'd1, 8'd5, 8'd7, 8'd0, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 8'd1, 8'd5, 8'd7, 8'd0, 1'b0, 1'b1};
    vecs[23] = '{1'b0, 1'b0, 8'd1, 8'd5, 8'd7, 8'd0, 1'b0, 1'b0};

`ifdef SEQ_AUTOSTART_EN
    // Reset high for one cycle, then 12 cycles with no start.
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done5) pulses++;
    end
    chk_regs("autostart", a5, b5, c5, d5, 8'd1, 8'd5, 8'd7, 8'd0);
    chk("autostart_busy", {31'd0, busy5}, 32'd0);
    chk("autostart_pulses", pulses, 32'd1);
    chk_regs("autostart_n0", a0, b0, c0, d0, 8'd1, 8'd0, 8'd2, 8'd0);
`else
    // Reset state is visible without any clock edge.
    #2;
    chk_regs("reset_state", a5, b5, c5, d5, 8'd0, 8'd0, 8'd0, 8'd0);
    chk("reset_busy_done", {30'd0, busy5, done5}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Nothing starts on its own.
    repeat (4) @(negedge clk);
    chk("no_autostart_busy", {31'd0, busy5}, 32'd0);
    chk_regs("no_autostart", a5, b5, c5, d5, 8'd0, 8'd0, 8'd0, 8'd0);

    // Per-cycle vector table on the LOOP_N=5 instance.
    for (int i = 0; i < 24; i++) begin
      start5 = vecs[i].start;
      hold5  = vecs[i].hold;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {a5, b5, c5, d5, 6'd0, busy5, done5},
          {vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, 6'd0, vecs[i].busy, vecs[i].done});
    end
    start5 = 1'b0;
    hold5  = 1'b0;

    // Plain run latency and results.
    run_count(5, 40, edges);
    chk("lat_n5", edges, 32'd8);
    chk_regs("final_n5", a5, b5, c5, d5, 8'd1, 8'd5, 8'd7, 8'd0);

    // Hold for three cycles during LOOP delays done by exactly three.
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);              // b = 2 now
    hold5 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold_b%0d", i), b5, 32'd2);
    end
    hold5 = 1'b0;
    edges = 6;
    while (!done5 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    chk("lat_hold", edges, 32'd11);
    chk_regs("final_hold", a5, b5, c5, d5, 8'd1, 8'd5, 8'd7, 8'd0);
    @(negedge clk);

    // Asynchronous reset mid-LOOP at b=3 discards the run.
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_b", b5, 32'd3);
    #2 rst = 1'b1;
    #1;
    chk_regs("midrun_reset", a5, b5, c5, d5, 8'd0, 8'd0, 8'd0, 8'd0);
    chk("midrun_reset_busy", {30'd0, busy5, done5}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done5 || busy5) pulses++;
    end
    chk("after_reset_quiet", pulses, 32'd0);
    run_count(5, 40, edges);
    chk("lat_after_reset", edges, 32'd8);
    chk_regs("final_after_reset", a5, b5, c5, d5, 8'd1, 8'd5, 8'd7, 8'd0);

    // LOOP_N = 0 skips LOOP entirely.
    run_count(0, 20, edges);
    chk("lat_n0", edges, 32'd3);
    chk_regs("final_n0", a0, b0, c0, d0, 8'd1, 8'd0, 8'd2, 8'd0);

    // LOOP_N = 255: c wraps to 1.
    run_count(255, 400, edges);
    chk("lat_n255", edges, 32'd258);
    chk_regs("final_n255", a255, b255, c255, d255, 8'd1, 8'd255, 8'd1, 8'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
